inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of fetch address and PC fields.
REQ-002 Parameter DATA_WIDTH, default 32, width of instruction word.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-low; sampled on rising edge of clk.
REQ-005 W_pc  input  ADDR_WIDTH  fetch address presented by the PC stage.
REQ-006 pc_valid  input  1  W_pc holds a fetch request.
REQ-007 pc_ready  output  1  block accepts W_pc this cycle; a request is accepted when pc_valid and pc_ready are both 1.
REQ-008 flush  input  1  discard any in-flight or held fetch.
REQ-009 inst_req  output  1  memory request strobe.
REQ-010 inst_addr  output  ADDR_WIDTH  memory request address.
REQ-011 inst_addr_ok  input  1  memory accepted the request this cycle.
REQ-012 inst_data_ok  input  1  inst_rdata valid this cycle.
REQ-013 inst_rdata  input  DATA_WIDTH  returned instruction word.
REQ-014 id_valid  output  1  id_pc/id_inst/id_adel valid for decode.
REQ-015 id_ready  input  1  decode consumes the held word this cycle.
REQ-016 id_pc  output  ADDR_WIDTH  address of the delivered instruction.
REQ-017 id_inst  output  DATA_WIDTH  delivered instruction word.
REQ-018 id_adel  output  1  address-error flag: delivered address was not word aligned.

Function
REQ-019 The block SHALL be a state machine with states IDLE, REQ, WAIT, DROP, HOLD and at most one outstanding memory request.
REQ-020 pc_ready SHALL be 1 only in IDLE.
REQ-021 IDLE: on acceptance with flush=0, latch W_pc into addr_r; if W_pc[1:0]!=0 go HOLD with id_inst=0 and id_adel=1, no memory request; else go REQ. Acceptance with flush=1 SHALL be ignored (stay IDLE).
REQ-022 REQ: inst_req=1, inst_addr=addr_r; on inst_addr_ok=1 go WAIT, or DROP if flush=1 the same cycle; on flush=1 with inst_addr_ok=0 go IDLE (request withdrawn).
REQ-023 WAIT: on inst_data_ok=1 with flush=0, register id_inst=inst_rdata, id_pc=addr_r, id_adel=0, go HOLD; with flush=1 discard data, go IDLE; on flush=1 with inst_data_ok=0 go DROP.
REQ-024 DROP: flush ignored; on inst_data_ok=1 discard inst_rdata, go IDLE.
REQ-025 HOLD: id_valid=1; id_pc, id_inst, id_adel SHALL remain stable until the state exits; on id_ready=1 or flush=1 go IDLE.
REQ-026 inst_req SHALL be 1 only in REQ; inst_addr SHALL hold its last value outside REQ.
REQ-027 inst_addr_ok or inst_data_ok asserted in a state not expecting it SHALL be ignored.
REQ-028 Minimum latency: acceptance in cycle N, inst_req in N+1; with inst_addr_ok in N+1 and inst_data_ok in N+2, id_valid=1 in N+3.
REQ-029 A misaligned fetch SHALL raise id_valid in the cycle after acceptance.
REQ-030 Addresses SHALL be forwarded unmodified; no increment or wrap is performed in this block.

Reset
REQ-031 While rst=0 at a rising edge: state=IDLE, addr_r=0, inst_addr=0, id_pc=0, id_inst=0, id_adel=0.
REQ-032 While rst=0, pc_ready, inst_req and id_valid SHALL be driven 0.
REQ-033 Reset asserted in any state, including WAIT/DROP, SHALL abandon the request; a late inst_data_ok after reset SHALL be ignored in IDLE.

Verification
REQ-034 Basic fetch: W_pc=0x0000_0040 accepted cycle 0, addr_ok cycle 1, data_ok cycle 2 with rdata=0x2408_0005 -> cycle 3 id_valid=1, id_pc=0x40, id_inst=0x2408_0005, id_adel=0.
REQ-035 Backpressure: hold id_ready=0 for 5 cycles in HOLD -> outputs stable, pc_ready=0; id_ready=1 -> IDLE, pc_ready=1 next cycle.
REQ-036 Flush in WAIT: flush in cycle 2 with data_ok delayed to cycle 4 (rdata=0xDEAD_BEEF) -> DROP, no id_valid, IDLE in cycle 5.
REQ-037 Misaligned: W_pc=0x0000_0042 accepted -> no inst_req, next cycle id_valid=1, id_adel=1, id_inst=0, id_pc=0x42.
REQ-038 Withdraw: flush in REQ with addr_ok=0 -> inst_req=0 next cycle, IDLE; stray data_ok ignored.
REQ-039 Reset mid-WAIT: rst=0 for one cycle -> all outputs 0; data_ok after release produces no id_valid.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch front end: takes one PC at a time, issues a single memory
// request, and holds the returned word (or an address-error marker) for decode.
module inst_fetch #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] W_pc,
   input  logic                  pc_valid,
   output logic                  pc_ready,
   input  logic                  flush,
   output logic                  inst_req,
   output logic [ADDR_WIDTH-1:0] inst_addr,
   input  logic                  inst_addr_ok,
   input  logic                  inst_data_ok,
   input  logic [DATA_WIDTH-1:0] inst_rdata,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [ADDR_WIDTH-1:0] id_pc,
   output logic [DATA_WIDTH-1:0] id_inst,
   output logic                  id_adel
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_DROP,
      S_HOLD
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] inst_addr_q, inst_addr_d;
   logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
   logic [DATA_WIDTH-1:0] id_inst_q, id_inst_d;
   logic                  id_adel_q, id_adel_d;

   always_comb begin
      // NOTE: every next-state value defaults to its current value first so no
      // path through the case leaves a signal unassigned (no latches).
      state_d     = state_q;
      addr_d      = addr_q;
      inst_addr_d = inst_addr_q;
      id_pc_d     = id_pc_q;
      id_inst_d   = id_inst_q;
      id_adel_d   = id_adel_q;

      unique case (state_q)
         S_IDLE: begin
            if (pc_valid && !flush) begin
               addr_d = W_pc;
               if (W_pc[1:0] != 2'b00) begin
                  // Misaligned: deliver the error marker without touching memory.
                  id_pc_d   = W_pc;
                  id_inst_d = '0;
                  id_adel_d = 1'b1;
                  state_d   = S_HOLD;
               end else begin
                  inst_addr_d = W_pc;
                  state_d     = S_REQ;
               end
            end
         end

         S_REQ: begin
            if (inst_addr_ok) begin
               state_d = flush ? S_DROP : S_WAIT;
            end else if (flush) begin
               state_d = S_IDLE;
            end
         end

         S_WAIT: begin
            if (inst_data_ok) begin
               if (!flush) begin
                  id_inst_d = inst_rdata;
                  id_pc_d   = addr_q;
                  id_adel_d = 1'b0;
                  state_d   = S_HOLD;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (flush) begin
               // Memory still owes us a beat; swallow it before going idle.
               state_d = S_DROP;
            end
         end

         S_DROP: begin
            if (inst_data_ok) begin
               state_d = S_IDLE;
            end
         end

         S_HOLD: begin
            if (id_ready || flush) begin
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments; reset is
      // synchronous, so it is only seen at a rising edge.
      if (!rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         inst_addr_q <= '0;
         id_pc_q     <= '0;
         id_inst_q   <= '0;
         id_adel_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         inst_addr_q <= inst_addr_d;
         id_pc_q     <= id_pc_d;
         id_inst_q   <= id_inst_d;
         id_adel_q   <= id_adel_d;
      end
   end

   // Handshake strobes are forced low for as long as reset is held.
   assign pc_ready  = rst && (state_q == S_IDLE);
   assign inst_req  = rst && (state_q == S_REQ);
   assign id_valid  = rst && (state_q == S_HOLD);
   assign inst_addr = inst_addr_q;
   assign id_pc     = id_pc_q;
   assign id_inst   = id_inst_q;
   assign id_adel   = id_adel_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Scenario bench for inst_fetch; deliveries are predicted into a scoreboard
// and checked by a monitor when id_valid rises.
module tb_inst_fetch;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] W_pc;
   logic          pc_valid;
   logic          pc_ready;
   logic          flush;
   logic          inst_req;
   logic [AW-1:0] inst_addr;
   logic          inst_addr_ok;
   logic          inst_data_ok;
   logic [DW-1:0] inst_rdata;
   logic          id_valid;
   logic          id_ready;
   logic [AW-1:0] id_pc;
   logic [DW-1:0] id_inst;
   logic          id_adel;

   typedef struct packed {
      logic [AW-1:0] pc;
      logic [DW-1:0] inst;
      logic          adel;
   } deliv_t;

   deliv_t sb[$];
   deliv_t cur;
   logic   cur_ok = 1'b0;
   logic   prev_valid = 1'b0;
   int     total = 0;
   int     bad = 0;

   always #5 clk = ~clk;

   inst_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .W_pc(W_pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .flush(flush), .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_inst(id_inst),
      .id_adel(id_adel)
   );

   // Monitor: a new delivery pops the scoreboard; a held delivery must not change.
   always @(negedge clk) begin
      if (id_valid && !prev_valid) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            cur_ok = 1'b0;
            $display("FAIL unexpected_delivery got pc=%h inst=%h adel=%b want no id_valid",
                     id_pc, id_inst, id_adel);
         end else begin
            cur    = sb.pop_front();
            cur_ok = 1'b1;
            if ({id_pc, id_inst, id_adel} !== cur) begin
               bad++;
               $display("FAIL delivery got pc=%h inst=%h adel=%b want pc=%h inst=%h adel=%b",
                        id_pc, id_inst, id_adel, cur.pc, cur.inst, cur.adel);
            end
         end
      end else if (id_valid && prev_valid && cur_ok) begin
         total++;
         if ({id_pc, id_inst, id_adel} !== cur) begin
            bad++;
            $display("FAIL hold_stable got pc=%h inst=%h adel=%b want pc=%h inst=%h adel=%b",
                     id_pc, id_inst, id_adel, cur.pc, cur.inst, cur.adel);
         end
      end
      prev_valid = id_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic accept(input logic [AW-1:0] addr);
      W_pc     = addr;
      pc_valid = 1'b1;
      tick();
      pc_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; W_pc = 32'h44; pc_valid = 1'b1; flush = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; id_ready = 1'b0;
      tick();
      tick();
      total++;
      if ({pc_ready, inst_req, id_valid} !== 3'b000) begin
         bad++;
         $display("FAIL reset_strobes got %b want 000", {pc_ready, inst_req, id_valid});
      end
      total++;
      if ({inst_addr, id_pc, id_inst, id_adel} !== '0) begin
         bad++;
         $display("FAIL reset_regs got addr=%h pc=%h inst=%h adel=%b want all 0",
                  inst_addr, id_pc, id_inst, id_adel);
      end
      pc_valid = 1'b0;
      rst = 1'b1;
      tick();
      total++;
      if ({pc_ready, inst_req} !== 2'b10) begin
         bad++;
         $display("FAIL reset_release got ready/req=%b want 10", {pc_ready, inst_req});
      end
   endtask

   task automatic test_basic();
      W_pc = 32'h0000_0040; pc_valid = 1'b1;
      total++;
      if (pc_ready !== 1'b1) begin
         bad++; $display("FAIL basic_ready got %b want 1", pc_ready);
      end
      sb.push_back('{pc: 32'h40, inst: 32'h2408_0005, adel: 1'b0});
      tick();
      pc_valid = 1'b0;
      total++;
      if ({inst_req, inst_addr} !== {1'b1, 32'h40}) begin
         bad++; $display("FAIL basic_req got req=%b addr=%h want 1 00000040", inst_req, inst_addr);
      end
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      total++;
      if ({inst_req, id_valid} !== 2'b00) begin
         bad++; $display("FAIL basic_wait got req/valid=%b want 00", {inst_req, id_valid});
      end
      inst_data_ok = 1'b1; inst_rdata = 32'h2408_0005;
      tick();
      inst_data_ok = 1'b0; inst_rdata = '0;
      total++;
      if ({id_valid, pc_ready} !== 2'b10) begin
         bad++; $display("FAIL basic_hold got valid/ready=%b want 10", {id_valid, pc_ready});
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      total++;
      if ({id_valid, pc_ready} !== 2'b01) begin
         bad++; $display("FAIL basic_done got valid/ready=%b want 01", {id_valid, pc_ready});
      end
   endtask

   task automatic test_backpressure();
      accept(32'h0000_0100);
      sb.push_back('{pc: 32'h100, inst: 32'hCAFE_0001, adel: 1'b0});
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'hCAFE_0001;
      tick();
      inst_data_ok = 1'b0;
      for (int i = 0; i < 5; i++) begin
         // Stray memory strobes while holding must not disturb the held word.
         inst_addr_ok = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h0BAD_0000 + i;
         total++;
         if ({id_valid, pc_ready, id_pc, id_inst} !== {2'b10, 32'h100, 32'hCAFE_0001}) begin
            bad++;
            $display("FAIL backpressure cyc=%0d got valid=%b ready=%b pc=%h inst=%h want 1 0 00000100 cafe0001",
                     i, id_valid, pc_ready, id_pc, id_inst);
         end
         tick();
      end
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      total++;
      if ({id_valid, pc_ready} !== 2'b01) begin
         bad++; $display("FAIL backpressure_release got valid/ready=%b want 01", {id_valid, pc_ready});
      end
   endtask

   task automatic test_flush_wait();
      accept(32'h0000_0080);
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      flush = 1'b1;
      tick();
      total++;
      if ({id_valid, pc_ready} !== 2'b00) begin
         bad++; $display("FAIL flush_wait_drop got valid/ready=%b want 00", {id_valid, pc_ready});
      end
      tick();
      flush = 1'b0;
      total++;
      if (pc_ready !== 1'b0) begin
         bad++; $display("FAIL drop_ignores_flush got ready=%b want 0", pc_ready);
      end
      inst_data_ok = 1'b1; inst_rdata = 32'hDEAD_BEEF;
      tick();
      inst_data_ok = 1'b0; inst_rdata = '0;
      total++;
      if ({id_valid, pc_ready} !== 2'b01) begin
         bad++; $display("FAIL flush_wait_idle got valid/ready=%b want 01", {id_valid, pc_ready});
      end
   endtask

   task automatic test_misaligned();
      W_pc = 32'h0000_0042; pc_valid = 1'b1;
      sb.push_back('{pc: 32'h42, inst: 32'h0, adel: 1'b1});
      tick();
      pc_valid = 1'b0;
      total++;
      if ({inst_req, id_valid, inst_addr} !== {2'b01, 32'h80}) begin
         bad++;
         $display("FAIL misaligned got req=%b valid=%b addr=%h want 0 1 00000080",
                  inst_req, id_valid, inst_addr);
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      W_pc = 32'hFFFF_FFFD; pc_valid = 1'b1;
      sb.push_back('{pc: 32'hFFFF_FFFD, inst: 32'h0, adel: 1'b1});
      tick();
      pc_valid = 1'b0;
      total++;
      if ({inst_req, id_valid} !== 2'b01) begin
         bad++; $display("FAIL misaligned_top got req/valid=%b want 01", {inst_req, id_valid});
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++;
      if ({id_valid, pc_ready} !== 2'b01) begin
         bad++; $display("FAIL hold_flush got valid/ready=%b want 01", {id_valid, pc_ready});
      end
   endtask

   task automatic test_withdraw();
      accept(32'h0000_0200);
      total++;
      if (inst_req !== 1'b1) begin
         bad++; $display("FAIL withdraw_req got %b want 1", inst_req);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total++;
      if ({inst_req, pc_ready} !== 2'b01) begin
         bad++; $display("FAIL withdraw got req/ready=%b want 01", {inst_req, pc_ready});
      end
      inst_data_ok = 1'b1; inst_rdata = 32'h5555_5555;
      tick();
      inst_data_ok = 1'b0;
      W_pc = 32'h0000_0300; pc_valid = 1'b1; flush = 1'b1;
      tick();
      pc_valid = 1'b0; flush = 1'b0;
      total++;
      if ({id_valid, pc_ready, inst_req, inst_addr} !== {3'b010, 32'h200}) begin
         bad++;
         $display("FAIL flush_accept got valid=%b ready=%b req=%b addr=%h want 0 1 0 00000200",
                  id_valid, pc_ready, inst_req, inst_addr);
      end
   endtask

   task automatic test_flush_req_ack();
      accept(32'h0000_0500);
      inst_addr_ok = 1'b1; flush = 1'b1;
      tick();
      inst_addr_ok = 1'b0; flush = 1'b0;
      total++;
      if ({inst_req, pc_ready} !== 2'b00) begin
         bad++; $display("FAIL req_flush_drop got req/ready=%b want 00", {inst_req, pc_ready});
      end
      inst_data_ok = 1'b1; inst_rdata = 32'h7777_7777;
      tick();
      inst_data_ok = 1'b0;
      accept(32'h0000_0600);
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; flush = 1'b1;
      tick();
      inst_data_ok = 1'b0; flush = 1'b0;
      total++;
      if ({id_valid, pc_ready} !== 2'b01) begin
         bad++; $display("FAIL wait_data_flush got valid/ready=%b want 01", {id_valid, pc_ready});
      end
   endtask

   task automatic test_back_to_back();
      accept(32'h0000_0400);
      sb.push_back('{pc: 32'h400, inst: 32'h1111_1111, adel: 1'b0});
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
      tick();
      inst_data_ok = 1'b0;
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
      total++;
      if (pc_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_ready got %b want 1", pc_ready);
      end
      sb.push_back('{pc: 32'h404, inst: 32'h2222_2222, adel: 1'b0});
      accept(32'h0000_0404);
      tick();
      total++;
      if ({inst_req, inst_addr} !== {1'b1, 32'h404}) begin
         bad++; $display("FAIL b2b_req_wait got req=%b addr=%h want 1 00000404", inst_req, inst_addr);
      end
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      tick();
      total++;
      if (id_valid !== 1'b0) begin
         bad++; $display("FAIL b2b_early got valid=%b want 0", id_valid);
      end
      inst_data_ok = 1'b1; inst_rdata = 32'h2222_2222;
      tick();
      inst_data_ok = 1'b0;
      total++;
      if (id_valid !== 1'b1) begin
         bad++; $display("FAIL b2b_deliver got valid=%b want 1", id_valid);
      end
      id_ready = 1'b1;
      tick();
      id_ready = 1'b0;
   endtask

   task automatic test_reset_wait();
      accept(32'h0000_0700);
      inst_addr_ok = 1'b1;
      tick();
      inst_addr_ok = 1'b0;
      rst = 1'b0;
      tick();
      total++;
      if ({pc_ready, inst_req, id_valid, inst_addr, id_pc, id_inst, id_adel} !== '0) begin
         bad++;
         $display("FAIL reset_wait got ready=%b req=%b valid=%b addr=%h pc=%h inst=%h adel=%b want all 0",
                  pc_ready, inst_req, id_valid, inst_addr, id_pc, id_inst, id_adel);
      end
      rst = 1'b1;
      inst_data_ok = 1'b1; inst_rdata = 32'h9999_9999;
      tick();
      inst_data_ok = 1'b0;
      tick();
      total++;
      if ({id_valid, pc_ready} !== 2'b01) begin
         bad++; $display("FAIL late_data got valid/ready=%b want 01", {id_valid, pc_ready});
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_flush_wait();
      test_misaligned();
      test_withdraw();
      test_flush_req_ack();
      test_back_to_back();
      test_reset_wait();
      tick();
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
